// File: rtl/encoder_digit_editor_if.sv
// Encoder editor bus: rotation/press/load inputs and BCD display outputs.
// Clock and reset stay as plain ports on the editor.
interface encoder_digit_editor_if #(
  parameter int NUM_DIGITS = 8
);
  localparam int CW = $clog2(NUM_DIGITS);

  logic                    i_Left;
  logic                    i_Right;
  logic                    i_Press;
  logic                    i_Load;
  logic [4*NUM_DIGITS-1:0] i_LoadValue;
  logic [4*NUM_DIGITS-1:0] o_Value;
  logic [CW-1:0]           o_Cursor;
  logic                    o_Editing;
  logic                    o_Selecting;
  logic [NUM_DIGITS-1:0]   o_Blank;
  logic                    o_Commit;

  modport master (
    output i_Left, i_Right, i_Press, i_Load, i_LoadValue,
    input  o_Value, o_Cursor, o_Editing, o_Selecting,
    input  o_Blank, o_Commit
  );

  modport slave (
    input  i_Left, i_Right, i_Press, i_Load, i_LoadValue,
    output o_Value, o_Cursor, o_Editing, o_Selecting,
    output o_Blank, o_Commit
  );
endinterface

// File: rtl/encoder_digit_editor.sv
// Rotary-encoder BCD digit editor: IDLE -> SELECT -> EDIT with cursor
// blink and inactivity timeout. All outputs registered.
module encoder_digit_editor #(
  parameter int NUM_DIGITS        = 8,
  parameter int BLINK_HALF_CYCLES = 12_500_000,
  parameter int TIMEOUT_CYCLES    = 250_000_000
) (
  input logic                  i_Clk,
  input logic                  i_Rst,
  encoder_digit_editor_if.slave bus
);
  localparam int CW = $clog2(NUM_DIGITS);
  localparam int BW = (BLINK_HALF_CYCLES > 1) ?
                      $clog2(BLINK_HALF_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ?
                      $clog2(TIMEOUT_CYCLES) : 1;
  localparam int VW = 4 * NUM_DIGITS;
  localparam logic [CW-1:0] CMAX = CW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BMAX = BW'(BLINK_HALF_CYCLES - 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SELECT,
    S_EDIT
  } state_t;

  state_t              r_state;
  logic [VW-1:0]       r_value;
  logic [CW-1:0]       r_cursor;
  logic [BW-1:0]       r_blink;
  logic                r_phase_on;
  logic [TW-1:0]       r_timeout;
  logic [NUM_DIGITS-1:0] r_blank;
  logic                r_commit;
  logic                r_editing;
  logic                r_selecting;

  state_t              w_state;
  logic [VW-1:0]       w_value;
  logic [CW-1:0]       w_cursor;
  logic [BW-1:0]       w_blink;
  logic                w_phase_on;
  logic [TW-1:0]       w_timeout;
  logic [NUM_DIGITS-1:0] w_blank;
  logic                w_commit;
  logic                w_rot_l;
  logic                w_rot_r;
  logic [3:0]          w_digit;
  logic [3:0]          w_dig_up;
  logic [3:0]          w_dig_dn;
  logic [CW-1:0]       w_cur_l;
  logic [CW-1:0]       w_cur_r;

  assign w_rot_l = bus.i_Left & ~bus.i_Right;
  assign w_rot_r = bus.i_Right & ~bus.i_Left;
  assign w_digit = r_value[{r_cursor, 2'b00} +: 4];

  // Out-of-range nibbles behave as 9 before wrapping
  assign w_dig_up = (w_digit >= 4'd9) ? 4'd0 : w_digit + 4'd1;
  assign w_dig_dn = (w_digit == 4'd0) ? 4'd9 :
                    (w_digit > 4'd9)  ? 4'd8 : w_digit - 4'd1;
  assign w_cur_l  = (r_cursor == CMAX) ? '0 : r_cursor + 1'b1;
  assign w_cur_r  = (r_cursor == '0) ? CMAX : r_cursor - 1'b1;

  always_comb begin
    w_state    = r_state;
    w_value    = r_value;
    w_cursor   = r_cursor;
    w_blink    = '0;
    w_phase_on = 1'b1;
    w_timeout  = '0;
    w_commit   = 1'b0;
    w_blank    = '0;
    if (bus.i_Load) begin
      w_value = bus.i_LoadValue;
      w_state = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.i_Press) w_state = S_SELECT;
        end
        S_SELECT, S_EDIT: begin
          w_timeout = r_timeout + 1'b1;
          if (r_blink == BMAX) begin
            w_blink    = '0;
            w_phase_on = ~r_phase_on;
          end else begin
            w_blink    = r_blink + 1'b1;
            w_phase_on = r_phase_on;
          end
          if (bus.i_Press) begin
            w_state    = (r_state == S_SELECT) ? S_EDIT : S_SELECT;
            w_timeout  = '0;
            w_blink    = '0;
            w_phase_on = 1'b1;
          end else if (w_rot_l || w_rot_r) begin
            w_timeout  = '0;
            w_blink    = '0;
            w_phase_on = 1'b1;
            if (r_state == S_SELECT) begin
              w_cursor = w_rot_l ? w_cur_l : w_cur_r;
            end else begin
              w_value[{r_cursor, 2'b00} +: 4] =
                w_rot_r ? w_dig_up : w_dig_dn;
            end
          end else if (r_timeout == TMAX) begin
            w_state   = S_IDLE;
            w_commit  = 1'b1;
            w_timeout = '0;
          end
        end
        default: w_state = S_IDLE;
      endcase
    end
    if (w_state != S_IDLE) begin
      w_blank[w_cursor] = ~w_phase_on;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_state     <= S_IDLE;
      r_value     <= '0;
      r_cursor    <= CMAX;
      r_blink     <= '0;
      r_phase_on  <= 1'b1;
      r_timeout   <= '0;
      r_blank     <= '0;
      r_commit    <= 1'b0;
      r_editing   <= 1'b0;
      r_selecting <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_value     <= w_value;
      r_cursor    <= w_cursor;
      r_blink     <= w_blink;
      r_phase_on  <= w_phase_on;
      r_timeout   <= w_timeout;
      r_blank     <= w_blank;
      r_commit    <= w_commit;
      r_editing   <= (w_state == S_EDIT);
      r_selecting <= (w_state == S_SELECT);
    end
  end

  assign bus.o_Value     = r_value;
  assign bus.o_Cursor    = r_cursor;
  assign bus.o_Editing   = r_editing;
  assign bus.o_Selecting = r_selecting;
  assign bus.o_Blank     = r_blank;
  assign bus.o_Commit    = r_commit;
endmodule
